// File: rtl/apb_rx_pkg.sv
// Shared constants and state types for the receive-side APB status poller.
package apb_rx_pkg;

   localparam int unsigned AddrReceive = 5;
   localparam int unsigned AddrId      = 6;
   localparam int unsigned AddrData    = 7;
   localparam int unsigned AddrStatus  = 8;
   localparam int unsigned AddrCmd     = 9;

   localparam int unsigned StatusPendingBit = 0;
   localparam int unsigned StatusBusyBit    = 7;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StStatus,
      StId,
      StData,
      StCmd,
      StRecv,
      StPresent
   } seq_state_e;

   typedef enum logic [1:0] {
      RdIdle,
      RdSetup,
      RdAccess,
      RdCapture
   } rd_state_e;

   function automatic logic status_ready(input logic [7:0] status);
      return status[StatusPendingBit] && !status[StatusBusyBit];
   endfunction

endpackage

// File: rtl/apb_rx_read_port.sv
// Single-read APB engine: one SETUP/ACCESS(/CAPTURE) transfer per start, with a
// bounded wait on PREADY.
module apb_rx_read_port
   import apb_rx_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 4,
   parameter int unsigned DATAWIDTH    = 16,
   parameter int unsigned TIMEOUT      = 15,
   parameter int unsigned READ_LAT     = 1
) (
   input  logic                    PCLK_rx,
   input  logic                    PRESETn_rx,
   input  logic                    start_i,
   input  logic [ADDRESSWIDTH-1:0] addr_i,
   output logic                    done_o,
   output logic [DATAWIDTH-1:0]    data_o,
   output logic                    timeout_o,
   output logic [ADDRESSWIDTH-1:0] paddr_o,
   output logic                    psel_o,
   output logic                    penable_o,
   input  logic [DATAWIDTH-1:0]    prdata_i,
   input  logic                    pready_i
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   rd_state_e               state_q, state_d;
   logic [TW-1:0]           acc_cnt_q, acc_cnt_d;
   logic [ADDRESSWIDTH-1:0] paddr_q;
   logic                    timeout_q, timeout_d;
   logic                    expire;
   logic                    launch;

   assign expire = (state_q == RdAccess) && !pready_i && (acc_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      timeout_d = 1'b0;
      done_o    = 1'b0;
      unique case (state_q)
         RdIdle: begin
            if (start_i) state_d = RdSetup;
         end
         RdSetup: begin
            state_d   = RdAccess;
            acc_cnt_d = '0;
         end
         RdAccess: begin
            if (pready_i) begin
               if (READ_LAT != 0) begin
                  state_d = RdCapture;
               end else begin
                  done_o  = 1'b1;
                  state_d = start_i ? RdSetup : RdIdle;
               end
            end else if (expire) begin
               timeout_d = 1'b1;
               state_d   = RdIdle;
            end else begin
               acc_cnt_d = acc_cnt_q + TW'(1);
            end
         end
         RdCapture: begin
            done_o  = 1'b1;
            state_d = start_i ? RdSetup : RdIdle;
         end
         default: state_d = RdIdle;
      endcase
   end

   // A new address is accepted when idle or back-to-back on the completing cycle.
   assign launch = start_i && ((state_q == RdIdle) || done_o);

   always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
      if (!PRESETn_rx) begin
         state_q   <= RdIdle;
         acc_cnt_q <= '0;
         paddr_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         timeout_q <= timeout_d;
         if (launch) paddr_q <= addr_i;
      end
   end

   assign paddr_o   = paddr_q;
   assign psel_o    = (state_q == RdSetup) || (state_q == RdAccess);
   assign penable_o = (state_q == RdAccess);
   assign data_o    = prdata_i;
   assign timeout_o = timeout_q;

endmodule

// File: rtl/apb_rx_poller.sv
// Polls the receiver status register and, when a frame is pending, reads it out
// and offers it on a valid/ready stream.
module apb_rx_poller
   import apb_rx_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH  = 4,
   parameter int unsigned DATAWIDTH     = 16,
   parameter int unsigned POLL_INTERVAL = 16,
   parameter int unsigned TIMEOUT       = 15,
   parameter int unsigned READ_LAT      = 1
) (
   input  logic                    PCLK_rx,
   input  logic                    PRESETn_rx,
   output logic [ADDRESSWIDTH-1:0] PADDR_rx_o,
   output logic                    PWRITE_rx_o,
   output logic                    PSELx_rx_o,
   output logic                    PENABLE_rx_o,
   input  logic [DATAWIDTH-1:0]    PRDATA_rx_i,
   input  logic                    PREADY_rx_i,
   input  logic                    enable_i,
   output logic                    frame_valid_o,
   input  logic                    frame_ready_i,
   output logic [7:0]              frame_id_o,
   output logic [15:0]             frame_data_o,
   output logic [7:0]              frame_cmd_o,
   output logic [7:0]              frame_status_o,
   output logic [11:0]             frame_raw_o,
   output logic                    timeout_err_o
);

   localparam int unsigned PW = $clog2(POLL_INTERVAL + 1);
   localparam logic [PW-1:0] PollReload = PW'(POLL_INTERVAL - 1);

   seq_state_e              state_q, state_d;
   logic [PW-1:0]           poll_cnt_q, poll_cnt_d;
   logic [7:0]              status_q, id_q, cmd_q;
   logic [15:0]             data_q;
   logic                    cap_status, cap_id, cap_data, cap_cmd, load_frame;

   logic                    frame_valid_q;
   logic [7:0]              frame_id_q, frame_cmd_q, frame_status_q;
   logic [15:0]             frame_data_q;
   logic [11:0]             frame_raw_q;

   logic                    rd_start, rd_done, rd_timeout;
   logic [ADDRESSWIDTH-1:0] rd_addr;
   logic [DATAWIDTH-1:0]    rd_data;
   logic [15:0]             rd_data16;

   assign rd_data16 = 16'(rd_data);

   apb_rx_read_port #(
      .ADDRESSWIDTH (ADDRESSWIDTH),
      .DATAWIDTH    (DATAWIDTH),
      .TIMEOUT      (TIMEOUT),
      .READ_LAT     (READ_LAT)
   ) u_read_port (
      .PCLK_rx    (PCLK_rx),
      .PRESETn_rx (PRESETn_rx),
      .start_i    (rd_start),
      .addr_i     (rd_addr),
      .done_o     (rd_done),
      .data_o     (rd_data),
      .timeout_o  (rd_timeout),
      .paddr_o    (PADDR_rx_o),
      .psel_o     (PSELx_rx_o),
      .penable_o  (PENABLE_rx_o),
      .prdata_i   (PRDATA_rx_i),
      .pready_i   (PREADY_rx_i)
   );

   always_comb begin
      state_d    = state_q;
      poll_cnt_d = poll_cnt_q;
      rd_start   = 1'b0;
      rd_addr    = ADDRESSWIDTH'(AddrStatus);
      cap_status = 1'b0;
      cap_id     = 1'b0;
      cap_data   = 1'b0;
      cap_cmd    = 1'b0;
      load_frame = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable_i) begin
               state_d    = StWait;
               poll_cnt_d = PollReload;
            end
         end
         StWait: begin
            if (!enable_i) begin
               state_d = StIdle;
            end else if (poll_cnt_q == '0) begin
               rd_start = 1'b1;
               rd_addr  = ADDRESSWIDTH'(AddrStatus);
               state_d  = StStatus;
            end else begin
               poll_cnt_d = poll_cnt_q - PW'(1);
            end
         end
         StStatus: begin
            if (rd_done) begin
               cap_status = 1'b1;
               if (status_ready(rd_data16[7:0])) begin
                  rd_start = 1'b1;
                  rd_addr  = ADDRESSWIDTH'(AddrId);
                  state_d  = StId;
               end else begin
                  state_d    = StWait;
                  poll_cnt_d = PollReload;
               end
            end
         end
         StId: begin
            if (rd_done) begin
               cap_id   = 1'b1;
               rd_start = 1'b1;
               rd_addr  = ADDRESSWIDTH'(AddrData);
               state_d  = StData;
            end
         end
         StData: begin
            if (rd_done) begin
               cap_data = 1'b1;
               rd_start = 1'b1;
               rd_addr  = ADDRESSWIDTH'(AddrCmd);
               state_d  = StCmd;
            end
         end
         StCmd: begin
            if (rd_done) begin
               cap_cmd  = 1'b1;
               rd_start = 1'b1;
               rd_addr  = ADDRESSWIDTH'(AddrReceive);
               state_d  = StRecv;
            end
         end
         StRecv: begin
            if (rd_done) begin
               load_frame = 1'b1;
               state_d    = StPresent;
            end
         end
         StPresent: begin
            if (frame_ready_i) begin
               state_d    = StWait;
               poll_cnt_d = PollReload;
            end
         end
         default: state_d = StIdle;
      endcase
      // An aborted read drops whatever was gathered so far.
      if (rd_timeout) begin
         rd_start   = 1'b0;
         state_d    = StWait;
         poll_cnt_d = PollReload;
      end
   end

   always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
      if (!PRESETn_rx) begin
         state_q        <= StIdle;
         poll_cnt_q     <= '0;
         status_q       <= '0;
         id_q           <= '0;
         data_q         <= '0;
         cmd_q          <= '0;
         frame_valid_q  <= 1'b0;
         frame_id_q     <= '0;
         frame_data_q   <= '0;
         frame_cmd_q    <= '0;
         frame_status_q <= '0;
         frame_raw_q    <= '0;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         if (cap_status) status_q <= rd_data16[7:0];
         if (cap_id)     id_q     <= rd_data16[7:0];
         if (cap_data)   data_q   <= rd_data16;
         if (cap_cmd)    cmd_q    <= rd_data16[7:0];
         if (load_frame) begin
            frame_valid_q  <= 1'b1;
            frame_id_q     <= id_q;
            frame_data_q   <= data_q;
            frame_cmd_q    <= cmd_q;
            frame_status_q <= status_q;
            frame_raw_q    <= rd_data16[11:0];
         end else if (frame_valid_q && frame_ready_i) begin
            frame_valid_q <= 1'b0;
         end
      end
   end

   assign PWRITE_rx_o    = 1'b0;
   assign frame_valid_o  = frame_valid_q;
   assign frame_id_o     = frame_id_q;
   assign frame_data_o   = frame_data_q;
   assign frame_cmd_o    = frame_cmd_q;
   assign frame_status_o = frame_status_q;
   assign frame_raw_o    = frame_raw_q;
   assign timeout_err_o  = rd_timeout;

endmodule

// File: tb/tb_apb_rx_poller.sv
// Scoreboard bench for apb_rx_poller: a register responder, queued expected reads
// and frames, and a negedge monitor that checks whatever the DUT presents.
module tb_apb_rx_poller;

   typedef struct packed {
      logic [7:0]  id;
      logic [15:0] data;
      logic [7:0]  cmd;
      logic [7:0]  status;
      logic [11:0] raw;
   } frame_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  paddr;
   logic        pwrite, psel, penable;
   logic [15:0] prdata;
   logic        pready;
   logic        enable;
   logic        f_valid, f_ready;
   logic [7:0]  f_id, f_cmd, f_status;
   logic [15:0] f_data;
   logic [11:0] f_raw;
   logic        to_err;

   logic [15:0] regs [16];
   logic        stall_en;
   logic [3:0]  stall_addr;

   logic [3:0]  exp_addr_q [$];
   frame_t      exp_frame_q [$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_run = 0;
   int          to_count = 0;
   int          last_status_setup = -1;
   bit          poll_chk = 1'b0;
   logic        valid_prev = 1'b0;
   logic        hs_prev = 1'b0;
   frame_t      prev_frame;
   frame_t      cur_frame;
   frame_t      exp_f;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign prdata = regs[paddr];
   assign pready = !(stall_en && (paddr == stall_addr));
   assign cur_frame = '{id: f_id, data: f_data, cmd: f_cmd, status: f_status, raw: f_raw};

   apb_rx_poller #(
      .ADDRESSWIDTH  (4),
      .DATAWIDTH     (16),
      .POLL_INTERVAL (16),
      .TIMEOUT       (15),
      .READ_LAT      (1)
   ) dut (
      .PCLK_rx        (clk),
      .PRESETn_rx     (rstn),
      .PADDR_rx_o     (paddr),
      .PWRITE_rx_o    (pwrite),
      .PSELx_rx_o     (psel),
      .PENABLE_rx_o   (penable),
      .PRDATA_rx_i    (prdata),
      .PREADY_rx_i    (pready),
      .enable_i       (enable),
      .frame_valid_o  (f_valid),
      .frame_ready_i  (f_ready),
      .frame_id_o     (f_id),
      .frame_data_o   (f_data),
      .frame_cmd_o    (f_cmd),
      .frame_status_o (f_status),
      .frame_raw_o    (f_raw),
      .timeout_err_o  (to_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rstn) begin
         valid_prev = 1'b0;
         hs_prev    = 1'b0;
         acc_run    = 0;
      end else begin
         if (psel && !penable && paddr == 4'd8) begin
            if (poll_chk && last_status_setup >= 0)
               check("poll period", 64'(cyc - last_status_setup), 64'd19);
            last_status_setup = cyc;
         end
         if (psel && penable) begin
            if (pready) begin
               acc_run = 0;
               if (exp_addr_q.size() == 0) flag("apb addr unexpected", 64'(paddr));
               else check("apb addr", 64'(paddr), 64'(exp_addr_q.pop_front()));
               check("pwrite", 64'(pwrite), 64'd0);
            end else begin
               acc_run++;
            end
         end
         if (to_err) begin
            to_count++;
            check("timeout access cycles", 64'(acc_run), 64'd15);
            check("psel at timeout", 64'(psel), 64'd0);
            acc_run = 0;
         end
         if (f_valid) check("apb idle while valid", 64'(psel), 64'd0);
         if (f_valid && !valid_prev) begin
            if (exp_frame_q.size() == 0) flag("frame unexpected", 64'(cur_frame));
            else check("frame latency", 64'(cyc - last_status_setup), 64'd15);
         end
         if (valid_prev && !hs_prev)
            check("frame held", 64'({f_valid, cur_frame}), 64'({1'b1, prev_frame}));
         if (hs_prev) check("valid after handshake", 64'(f_valid), 64'd0);
         if (f_valid && f_ready) begin
            if (exp_frame_q.size() == 0) begin
               flag("frame handshake unexpected", 64'(cur_frame));
            end else begin
               exp_f = exp_frame_q.pop_front();
               check("frame fields", 64'(cur_frame), 64'(exp_f));
            end
         end
         valid_prev = f_valid;
         hs_prev    = f_valid && f_ready;
         prev_frame = cur_frame;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((exp_addr_q.size() != 0 || exp_frame_q.size() != 0) && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (exp_addr_q.size() != 0 || exp_frame_q.size() != 0) begin
         errors++;
         $display("FAIL %s drain: got %0d reads and %0d frames outstanding, expected 0",
                  name, exp_addr_q.size(), exp_frame_q.size());
      end
   endtask

   task automatic stop_poll();
      enable = 1'b0;
      tick(25);
   endtask

   task automatic push_frame_reads();
      exp_addr_q.push_back(4'd8);
      exp_addr_q.push_back(4'd6);
      exp_addr_q.push_back(4'd7);
      exp_addr_q.push_back(4'd9);
      exp_addr_q.push_back(4'd5);
   endtask

   task automatic check_all_zero(input string name);
      check({name, " psel"}, 64'(psel), 64'd0);
      check({name, " penable"}, 64'(penable), 64'd0);
      check({name, " paddr"}, 64'(paddr), 64'd0);
      check({name, " pwrite"}, 64'(pwrite), 64'd0);
      check({name, " valid"}, 64'(f_valid), 64'd0);
      check({name, " frame"}, 64'(cur_frame), 64'd0);
      check({name, " timeout"}, 64'(to_err), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
      rstn = 1'b0; enable = 1'b0; f_ready = 1'b1; stall_en = 1'b0; stall_addr = 4'd0;
      #1;
      check_all_zero("reset");
      tick(3);
      rstn = 1'b1;
      tick(2);

      // Status never pending: only status polls, fixed period
      last_status_setup = -1;
      poll_chk = 1'b1;
      repeat (3) exp_addr_q.push_back(4'd8);
      enable = 1'b1;
      drain(120, "idle polls");
      stop_poll();
      poll_chk = 1'b0;

      // Ready frame
      regs[8] = 16'h0001; regs[6] = 16'h0023; regs[7] = 16'hBEEF;
      regs[9] = 16'h0042; regs[5] = 16'h0ABC;
      push_frame_reads();
      exp_frame_q.push_back('{id: 8'h23, data: 16'hBEEF, cmd: 8'h42, status: 8'h01, raw: 12'hABC});
      enable = 1'b1;
      drain(80, "frame");
      stop_poll();

      // Busy status: frame skipped
      regs[8] = 16'h0081;
      exp_addr_q.push_back(4'd8);
      enable = 1'b1;
      drain(40, "busy");
      stop_poll();

      // Timeout on the DATA read
      regs[8] = 16'h0001;
      stall_addr = 4'd7; stall_en = 1'b1;
      to_count = 0;
      exp_addr_q.push_back(4'd8);
      exp_addr_q.push_back(4'd6);
      enable = 1'b1;
      drain(40, "pre-timeout");
      n = 0;
      while (to_count == 0 && n < 40) begin tick(1); n++; end
      check("timeout seen", 64'(to_count), 64'd1);
      stall_en = 1'b0;
      regs[8] = 16'h0000;
      exp_addr_q.push_back(4'd8);
      drain(40, "post-timeout");
      stop_poll();
      check("timeout pulse count", 64'(to_count), 64'd1);

      // Back-pressure: frame held while not accepted, low bits taken
      regs[8] = 16'h0001; regs[6] = 16'h125A; regs[7] = 16'h1234;
      regs[9] = 16'h3C7E; regs[5] = 16'hF0F1;
      push_frame_reads();
      exp_frame_q.push_back('{id: 8'h5A, data: 16'h1234, cmd: 8'h7E, status: 8'h01, raw: 12'h0F1});
      f_ready = 1'b0;
      enable = 1'b1;
      n = 0;
      while (!f_valid && n < 80) begin tick(1); n++; end
      check("valid rises", 64'(f_valid), 64'd1);
      enable = 1'b0;
      tick(10);
      check("valid still held", 64'(f_valid), 64'd1);
      f_ready = 1'b1;
      drain(10, "backpressure");
      tick(25);

      // Reset during the CMD access, then a clean restart
      regs[6] = 16'h0023; regs[7] = 16'hBEEF; regs[9] = 16'h0042; regs[5] = 16'h0ABC;
      stall_addr = 4'd9; stall_en = 1'b1;
      exp_addr_q.push_back(4'd8);
      exp_addr_q.push_back(4'd6);
      exp_addr_q.push_back(4'd7);
      enable = 1'b1;
      drain(60, "pre-reset");
      n = 0;
      while (!(psel && penable && paddr == 4'd9) && n < 20) begin @(negedge clk); n++; end
      check("in cmd access", 64'(psel && penable && paddr == 4'd9), 64'd1);
      rstn = 1'b0;
      #1;
      check_all_zero("mid-transfer reset");
      tick(3);
      stall_en = 1'b0;
      push_frame_reads();
      exp_frame_q.push_back('{id: 8'h23, data: 16'hBEEF, cmd: 8'h42, status: 8'h01, raw: 12'hABC});
      rstn = 1'b1;
      drain(80, "restart");
      stop_poll();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
